fetch_unit: RTL and testbench

Instruction fetch stage feeding the main decoder. It owns the PC register, issues word reads to instruction memory over a request/grant + in-order response interface, and buffers returned words in a small FIFO. The decode stage consumes the words through a valid/ready handshake. On a taken branch or jump (PCSrc from the main decoder) it flushes the buffer, drops in-flight responses and refetches from PCTarget.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/fetch_fifo.sv | 52 +++++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the fetch stage and the main decoder.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b000_0011,
    OPC_OP_IMM = 7'b001_0011,
    OPC_AUIPC  = 7'b001_0111,
    OPC_STORE  = 7'b010_0011,
    OPC_OP     = 7'b011_0011,
    OPC_LUI    = 7'b011_0111,
    OPC_BRANCH = 7'b110_0011,
    OPC_JALR   = 7'b110_0111,
    OPC_JAL    = 7'b110_1111
  } opcode_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two so pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: storage is deliberately not reset; validity lives in the pointers and count only.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, credit-limited memory requests, buffered words to decode,
// and flush/refetch on a redirect accepted with the head instruction.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
  parameter int              FIFO_DEPTH      = 2,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_GNT,
  input  logic            IMEM_RVALID,
  input  logic [XLEN-1:0] IMEM_RDATA,
  output logic            INSTR_VALID,
  input  logic            INSTR_READY,
  output logic [XLEN-1:0] INSTR,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] MAX_OUT = CW'(MAX_OUTSTANDING);
  localparam logic [QW-1:0] Q_LAST  = QW'(MAX_OUTSTANDING - 1);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_n;
  logic [CW-1:0]   drop;
  logic [XLEN-1:0] pc_q [MAX_OUTSTANDING];
  logic [QW-1:0]   q_wr;
  logic [QW-1:0]   q_rd;

  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic [FW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;

  logic            credit;
  logic            grant;
  logic            accept;
  logic            redirect;
  logic            push;

  // Words still owed to the FIFO (in flight minus those to be dropped) plus buffered words
  // must fit in the FIFO; a pop in the current cycle earns no credit.
  // NOTE: default assignment first so no path through the block leaves credit unassigned (no latch).
  always_comb begin
    credit = 1'b0;
    if (outstanding < MAX_OUT)
      credit = (int'(outstanding) - int'(drop) + int'(fifo_count)) < FIFO_DEPTH;
  end

  assign IMEM_REQ      = credit & ~RST;
  assign IMEM_ADDR     = fetch_pc;
  assign grant         = IMEM_REQ & IMEM_GNT;
  assign accept        = ~fifo_empty & INSTR_READY;
  assign redirect      = accept & PCSrc;
  assign push          = IMEM_RVALID & (drop == '0) & (~fifo_full | accept);
  assign outstanding_n = outstanding + CW'(grant) - CW'(IMEM_RVALID);
  assign push_entry    = '{pc: pc_q[q_rd], instr: IMEM_RDATA};

  always_ff @(posedge CLK) begin
    if (grant) pc_q[q_wr] <= fetch_pc;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
    end else begin
      outstanding <= outstanding_n;
      if (grant)       q_wr <= (q_wr == Q_LAST) ? '0 : q_wr + 1'b1;
      if (IMEM_RVALID) q_rd <= (q_rd == Q_LAST) ? '0 : q_rd + 1'b1;
      if (redirect) begin
        // Everything still in flight after this edge, including a same-cycle grant, is stale.
        fetch_pc <= word_align(PCTarget);
        drop     <= outstanding_n;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (IMEM_RVALID && drop != '0) drop <= drop - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_data (push_entry),
    .pop       (accept),
    .flush     (redirect),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign INSTR_VALID = ~fifo_empty;
  assign INSTR       = fifo_empty ? NOP_INSTR : head.instr;
  assign PC          = fifo_empty ? '0 : head.pc;
  assign PCPlus4     = PC + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an in-order memory model with configurable latency
// and an instruction-stream reference (sequential PCs, restarted at each accepted redirect).
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          MAX_OUT  = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT    = 1'b0;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA  = '0;
  logic        INSTR_VALID;
  logic        INSTR_READY = 1'b0;
  logic [31:0] INSTR;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        PCSrc       = 1'b0;
  logic [31:0] PCTarget    = '0;

  fetch_unit #(
    .RESET_PC        (RESET_PC),
    .FIFO_DEPTH      (2),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IMEM_REQ    (IMEM_REQ),
    .IMEM_ADDR   (IMEM_ADDR),
    .IMEM_GNT    (IMEM_GNT),
    .IMEM_RVALID (IMEM_RVALID),
    .IMEM_RDATA  (IMEM_RDATA),
    .INSTR_VALID (INSTR_VALID),
    .INSTR_READY (INSTR_READY),
    .INSTR       (INSTR),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .PCSrc       (PCSrc),
    .PCTarget    (PCTarget)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc;
  int          model_out;
  int          accepted = 0;
  int          first_valid;
  int          throttle_seen;
  logic [31:0] exp_pc;
  int          gnt_pct, ready_pct, redir_pct, lat_min, lat_max;
  logic        force_en = 1'b0;
  logic [31:0] force_pc, force_tgt;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(IMEM_REQ),    32'd0);
    check({tag, "_addr"},  IMEM_ADDR,        RESET_PC);
    check({tag, "_valid"}, 32'(INSTR_VALID), 32'd0);
    check({tag, "_instr"}, INSTR,            NOP_INSTR);
    check({tag, "_pc"},    PC,               32'd0);
    check({tag, "_pc4"},   PCPlus4,          32'd4);
  endtask

  // Called at a falling edge: asserts reset mid-cycle, checks outputs at once, then releases.
  task automatic apply_reset(input string tag);
    RST = 1'b1;
    IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = '0;
    INSTR_READY = 1'b0; PCSrc = 1'b0; PCTarget = '0;
    #1;
    check_reset_outputs(tag);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    mq.delete();
    model_out   = 0;
    exp_pc      = RESET_PC;
    cyc         = 1;
    first_valid = 0;
    #1;
    check({tag, "_first_req"},  32'(IMEM_REQ), 32'd1);
    check({tag, "_first_addr"}, IMEM_ADDR,     RESET_PC);
  endtask

  // One clock cycle: sample outputs, drive inputs, check, update the model, advance to next falling edge.
  task automatic step();
    logic        req, vld, gnt, rsp, rdy, src;
    logic [31:0] addr, ins, pc, pc4, tgt;
    req = IMEM_REQ; addr = IMEM_ADDR; vld = INSTR_VALID; ins = INSTR; pc = PC; pc4 = PCPlus4;

    gnt = ($urandom_range(99) < gnt_pct);
    rsp = (mq.size() > 0) && (mq[0].due <= cyc);
    rdy = ($urandom_range(99) < ready_pct);
    src = ($urandom_range(99) < redir_pct);
    tgt = $urandom;
    if (force_en && vld && pc == force_pc) begin
      rdy = 1'b1; src = 1'b1; tgt = force_tgt; force_en = 1'b0;
    end
    IMEM_GNT    = gnt;
    IMEM_RVALID = rsp;
    IMEM_RDATA  = rsp ? memword(mq[0].addr) : $urandom;
    INSTR_READY = rdy;
    PCSrc       = src;
    PCTarget    = tgt;

    if (vld && first_valid == 0) first_valid = cyc;
    if (!req && model_out == MAX_OUT) throttle_seen = 1;
    if (req) begin
      check("req_within_limit", 32'(model_out < MAX_OUT), 32'd1);
      check("addr_aligned", {30'd0, addr[1:0]}, 32'd0);
    end
    if (vld) begin
      check("pcplus4", pc4, pc + 32'd4);
      if (rdy) begin
        check("stream_pc", pc, exp_pc);
        check("stream_instr", ins, memword(exp_pc));
        exp_pc = src ? {tgt[31:2], 2'b00} : exp_pc + 32'd4;
        accepted++;
      end
    end else begin
      check("empty_instr", ins, NOP_INSTR);
      check("empty_pc", pc, 32'd0);
      check("empty_pc4", pc4, 32'd4);
    end

    if (rsp) begin
      void'(mq.pop_front());
      model_out--;
    end
    if (req && gnt) begin
      mq.push_back('{addr: addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
      model_out++;
    end
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
  endtask

  task automatic run_accepts(input int n, input int budget, input string tag);
    int start;
    start = accepted;
    for (int i = 0; i < budget && accepted - start < n; i++) step();
    check({tag, "_progress"}, 32'(accepted - start >= n), 32'd1);
  endtask

  task automatic redirect_at(input logic [31:0] at_pc, input logic [31:0] tgt, input string tag);
    force_pc  = at_pc;
    force_tgt = tgt;
    force_en  = 1'b1;
    for (int i = 0; i < 100 && force_en; i++) step();
    check({tag, "_fired"}, 32'(force_en), 32'd0);
    force_en = 1'b0;
  endtask

  initial begin
    int start;
    gnt_pct = 100; ready_pct = 100; redir_pct = 0; lat_min = 1; lat_max = 1;
    throttle_seen = 0;

    apply_reset("reset");
    run_accepts(8, 60, "lat1");
    check("first_valid_cycle", first_valid, 32'd3);

    ready_pct = 0;
    repeat (10) step();
    check("stall_req_low", 32'(IMEM_REQ), 32'd0);
    check("stall_valid", 32'(INSTR_VALID), 32'd1);
    check("stall_head_pc", PC, exp_pc);
    ready_pct = 100;
    run_accepts(6, 60, "resume");

    lat_min = 3; lat_max = 3; throttle_seen = 0;
    run_accepts(20, 200, "lat3");
    check("lat3_throttle", throttle_seen, 32'd1);

    apply_reset("reset2");
    redirect_at(32'h8, 32'h100, "redir_pc8");
    check("redir_fetch_addr", IMEM_ADDR, 32'h100);
    run_accepts(4, 100, "after_redir");

    redirect_at(exp_pc + 32'd4, 32'h0000_0102, "redir_unaligned");
    check("unaligned_fetch_addr", IMEM_ADDR, 32'h100);
    run_accepts(3, 100, "after_unaligned");

    redirect_at(exp_pc + 32'd4, 32'hFFFF_FFFC, "redir_wrap");
    check("wrap_fetch_addr", IMEM_ADDR, 32'hFFFF_FFFC);
    run_accepts(4, 100, "after_wrap");

    lat_min = 1; lat_max = 4; gnt_pct = 70; ready_pct = 70; redir_pct = 8;
    start = accepted;
    repeat (3000) step();
    check("random_progress", 32'(accepted - start > 100), 32'd1);

    redir_pct = 0; gnt_pct = 100; ready_pct = 0; lat_min = 3; lat_max = 3;
    repeat (4) step();
    apply_reset("midrun_reset");
    ready_pct = 100;
    run_accepts(8, 100, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
